// File: rtl/sdram_dual_wr_arbiter.sv
// Merges two half-width camera write FIFOs into one SDRAM frame buffer.
// Arbitrates burst writes per camera and ping-pongs banks per completed dual frame.
module sdram_dual_wr_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int FIFO_LVL_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [11:0]           half_h_pixel,
    input  logic [12:0]           v_pixel,
    input  logic [9:0]            burst_len,
    input  logic                  pingpong_en,
    input  logic                  frame_start0,
    input  logic                  frame_start1,
    input  logic [FIFO_LVL_W-1:0] fifo0_level,
    input  logic [FIFO_LVL_W-1:0] fifo1_level,
    input  logic [15:0]           fifo0_data,
    input  logic [15:0]           fifo1_data,
    output logic                  fifo0_rden,
    output logic                  fifo1_rden,
    output logic                  sdram_wr_req,
    input  logic                  sdram_wr_ack,
    output logic [ADDR_W-1:0]     sdram_wr_addr,
    output logic [9:0]            sdram_wr_burst,
    output logic [15:0]           sdram_wr_data,
    output logic                  rd_bank
);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_DATA, S_UPDATE} state_t;

    state_t              state_q;
    logic                sel_q, prio_q, req_q, wr_bank_q, rd_bank_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [9:0]          burst_q;
    logic [1:0][11:0]    col_q;
    logic [1:0][12:0]    line_q;
    logic [1:0][21:0]    base_q;
    logic [1:0]          done_q, fs_pend_q;

    logic [1:0]              fs, eligible, active;
    logic [1:0][9:0]         blen_d;
    logic [1:0][ADDR_W-1:0]  cam_addr_d;
    logic [1:0][31:0]        level;
    logic [11:0]             remain;
    logic [21:0]             low;
    logic                    gnt_valid, gnt_sel, busy;
    logic [11:0]             col_sum_d;
    logic [12:0]             line_nxt_d;

    assign fs       = {frame_start1, frame_start0};
    assign level[0] = 32'(fifo0_level);
    assign level[1] = 32'(fifo1_level);
    assign busy     = (state_q == S_REQ) || (state_q == S_DATA) || (state_q == S_UPDATE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        remain     = '0;
        low        = '0;
        blen_d     = '0;
        eligible   = '0;
        cam_addr_d = '0;
        for (int k = 0; k < 2; k++) begin
            remain = (col_q[k] < half_h_pixel) ? half_h_pixel - col_q[k] : 12'd0;
            blen_d[k] = (remain > {2'b00, burst_len}) ? burst_len : remain[9:0];
            eligible[k] = !done_q[k] && (blen_d[k] != 10'd0) && (level[k] >= 32'(blen_d[k]));
            low = base_q[k] + ((k == 1) ? 22'(half_h_pixel) : 22'd0) + 22'(col_q[k]);
            cam_addr_d[k] = {{(ADDR_W-23){1'b0}}, wr_bank_q, low};
        end
    end

    // Both eligible: honour the round-robin pointer; otherwise grant whoever is ready.
    assign gnt_valid = |eligible;
    assign gnt_sel   = (eligible == 2'b11) ? prio_q : eligible[1];
    assign active[0] = (busy && !sel_q) || (state_q == S_ARB && gnt_valid && !gnt_sel);
    assign active[1] = (busy &&  sel_q) || (state_q == S_ARB && gnt_valid &&  gnt_sel);

    assign col_sum_d  = col_q[sel_q] + 12'(burst_q);
    assign line_nxt_d = line_q[sel_q] + 13'd1;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            prio_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            burst_q   <= '0;
            col_q     <= '0;
            line_q    <= '0;
            base_q    <= '0;
            done_q    <= '0;
            fs_pend_q <= '0;
            if (rst) begin
                wr_bank_q <= 1'b0;
                rd_bank_q <= 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_ARB;
                S_ARB: begin
                    if (gnt_valid) begin
                        sel_q   <= gnt_sel;
                        prio_q  <= ~gnt_sel;
                        addr_q  <= cam_addr_d[gnt_sel];
                        burst_q <= blen_d[gnt_sel];
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sdram_wr_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA:   if (!sdram_wr_ack) state_q <= S_UPDATE;
                S_UPDATE: state_q <= S_ARB;
                default:  state_q <= S_IDLE;
            endcase

            if (done_q == 2'b11) begin
                done_q <= 2'b00;
                if (pingpong_en) begin
                    wr_bank_q <= ~wr_bank_q;
                    rd_bank_q <= wr_bank_q;
                end else begin
                    rd_bank_q <= ~wr_bank_q;
                end
            end

            // A frame start for the camera in flight waits for UPDATE and overrides its result.
            for (int k = 0; k < 2; k++) begin
                if (state_q == S_UPDATE && sel_q == 1'(k)) begin
                    if (fs_pend_q[k] || fs[k]) begin
                        col_q[k]     <= '0;
                        line_q[k]    <= '0;
                        base_q[k]    <= '0;
                        done_q[k]    <= 1'b0;
                        fs_pend_q[k] <= 1'b0;
                    end else if (col_sum_d >= half_h_pixel) begin
                        col_q[k] <= '0;
                        if (line_nxt_d >= v_pixel) begin
                            line_q[k] <= '0;
                            base_q[k] <= '0;
                            done_q[k] <= 1'b1;
                        end else begin
                            line_q[k] <= line_nxt_d;
                            base_q[k] <= base_q[k] + {9'd0, half_h_pixel, 1'b0};
                        end
                    end else begin
                        col_q[k] <= col_sum_d;
                    end
                end else if (fs[k]) begin
                    if (active[k]) begin
                        fs_pend_q[k] <= 1'b1;
                    end else begin
                        col_q[k]  <= '0;
                        line_q[k] <= '0;
                        base_q[k] <= '0;
                        done_q[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign sdram_wr_req   = req_q;
    assign sdram_wr_addr  = addr_q;
    assign sdram_wr_burst = burst_q;
    assign rd_bank        = rd_bank_q;
    assign sdram_wr_data  = sel_q ? fifo1_data : fifo0_data;
    assign fifo0_rden     = sdram_wr_ack && (state_q == S_REQ || state_q == S_DATA) && !sel_q;
    assign fifo1_rden     = sdram_wr_ack && (state_q == S_REQ || state_q == S_DATA) &&  sel_q;

endmodule

// File: tb/tb_sdram_dual_wr_arbiter.sv
// Directed bench for sdram_dual_wr_arbiter: a behavioural SDRAM write port answers
// each request with an ack of the granted length; addresses/lengths are hand-computed.
module tb_sdram_dual_wr_arbiter;

    localparam logic [15:0] D0 = 16'hC0C0;
    localparam logic [15:0] D1 = 16'hC1C1;

    logic        clk = 1'b0;
    logic        rst, load, pingpong_en, frame_start0, frame_start1, sdram_wr_ack;
    logic [11:0] half_h_pixel;
    logic [12:0] v_pixel;
    logic [9:0]  burst_len;
    logic [10:0] fifo0_level, fifo1_level;
    logic [15:0] fifo0_data, fifo1_data;
    logic        fifo0_rden, fifo1_rden, sdram_wr_req, rd_bank;
    logic [23:0] sdram_wr_addr;
    logic [9:0]  sdram_wr_burst;
    logic [15:0] sdram_wr_data;

    int n_vec  = 0;
    int n_miss = 0;

    sdram_dual_wr_arbiter #(.ADDR_W(24), .FIFO_LVL_W(11)) dut (
        .clk(clk), .rst(rst), .load(load),
        .half_h_pixel(half_h_pixel), .v_pixel(v_pixel), .burst_len(burst_len),
        .pingpong_en(pingpong_en),
        .frame_start0(frame_start0), .frame_start1(frame_start1),
        .fifo0_level(fifo0_level), .fifo1_level(fifo1_level),
        .fifo0_data(fifo0_data), .fifo1_data(fifo1_data),
        .fifo0_rden(fifo0_rden), .fifo1_rden(fifo1_rden),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
        .sdram_wr_data(sdram_wr_data), .rd_bank(rd_bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sdram_wr_ack = 1'b0;
        frame_start0 = 1'b0;
        frame_start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic config_dut(input logic [11:0] hh, input logic [12:0] vp, input logic [9:0] bl,
                              input logic [10:0] l0, input logic [10:0] l1, input logic pp);
        half_h_pixel = hh;
        v_pixel      = vp;
        burst_len    = bl;
        fifo0_level  = l0;
        fifo1_level  = l1;
        pingpong_en  = pp;
    endtask

    // Wait for a request, check it, then ack it word by word; fs_at pulses frame_start0 mid-burst.
    task automatic serve(input string tag, input logic [23:0] exp_addr, input int exp_len,
                         input bit cam, input int fs_at);
        int wait_n, n_sel, n_oth, n_bad, len;
        wait_n = 0; n_sel = 0; n_oth = 0; n_bad = 0;
        @(negedge clk);
        while (!sdram_wr_req && wait_n < 3000) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_req"}, 32'(sdram_wr_req), 32'd1);
        if (!sdram_wr_req) return;
        check({tag, "_addr"}, 32'(sdram_wr_addr), 32'(exp_addr));
        check({tag, "_len"}, 32'(sdram_wr_burst), 32'(exp_len));
        len = int'(sdram_wr_burst);
        for (int i = 0; i < len; i++) begin
            sdram_wr_ack = 1'b1;
            frame_start0 = (i == fs_at);
            #1;
            if (cam ? fifo1_rden : fifo0_rden) n_sel++;
            if (cam ? fifo0_rden : fifo1_rden) n_oth++;
            if (sdram_wr_data !== (cam ? D1 : D0)) n_bad++;
            @(negedge clk);
        end
        sdram_wr_ack = 1'b0;
        frame_start0 = 1'b0;
        check({tag, "_rden_sel"}, 32'(n_sel), 32'(exp_len));
        check({tag, "_rden_other"}, 32'(n_oth), 32'd0);
        check({tag, "_data"}, 32'(n_bad), 32'd0);
    endtask

    initial begin
        int req_seen;
        fifo0_data = D0;
        fifo1_data = D1;
        load       = 1'b0;

        // Two cameras alternating, one line per burst, then a bank swap and a load.
        config_dut(12'd512, 13'd2, 10'd512, 11'd600, 11'd600, 1'b1);
        do_reset();
        #1;
        check("rst_req", 32'(sdram_wr_req), 32'd0);
        check("rst_addr", 32'(sdram_wr_addr), 32'd0);
        check("rst_burst", 32'(sdram_wr_burst), 32'd0);
        check("rst_rden", {30'd0, fifo1_rden, fifo0_rden}, 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd1);
        serve("t1_b0", 24'h000000, 512, 1'b0, -1);
        serve("t1_b1", 24'h000200, 512, 1'b1, -1);
        serve("t1_b2", 24'h000400, 512, 1'b0, -1);
        serve("t1_b3", 24'h000600, 512, 1'b1, -1);
        serve("t1_swap", 24'h400000, 512, 1'b0, -1);
        check("t1_rd_bank", 32'(rd_bank), 32'd0);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        serve("t1_load", 24'h400000, 512, 1'b0, -1);

        // Half-line not a multiple of the burst: short tail burst, then next line.
        config_dut(12'd400, 13'd4, 10'd256, 11'd600, 11'd0, 1'b1);
        do_reset();
        serve("t2_b0", 24'h000000, 256, 1'b0, -1);
        serve("t2_b1", 24'h000100, 144, 1'b0, -1);
        serve("t2_b2", 24'h000320, 256, 1'b0, -1);

        // FIFO level threshold: 100 and 255 hold off, 256 grants at once.
        config_dut(12'd512, 13'd4, 10'd256, 11'd100, 11'd0, 1'b1);
        do_reset();
        req_seen = 0;
        repeat (10) begin @(negedge clk); if (sdram_wr_req) req_seen++; end
        fifo0_level = 11'd255;
        repeat (10) begin @(negedge clk); if (sdram_wr_req) req_seen++; end
        check("t3_no_req", 32'(req_seen), 32'd0);
        fifo0_level = 11'd256;
        @(negedge clk);
        check("t3_req_now", 32'(sdram_wr_req), 32'd1);
        serve("t3_b0", 24'h000000, 256, 1'b0, -1);

        // Frame start during a cam0 burst at line 3 is deferred, then restarts the frame.
        config_dut(12'd512, 13'd8, 10'd512, 11'd600, 11'd0, 1'b1);
        do_reset();
        serve("t4_l0", 24'h000000, 512, 1'b0, -1);
        serve("t4_l1", 24'h000400, 512, 1'b0, -1);
        serve("t4_l2", 24'h000800, 512, 1'b0, -1);
        serve("t4_l3", 24'h000C00, 512, 1'b0, 100);
        serve("t4_restart", 24'h000000, 512, 1'b0, -1);

        // Ping-pong disabled: bank stays put, frames restart in bank 0.
        config_dut(12'd512, 13'd1, 10'd512, 11'd600, 11'd600, 1'b0);
        do_reset();
        serve("t5_f0c0", 24'h000000, 512, 1'b0, -1);
        serve("t5_f0c1", 24'h000200, 512, 1'b1, -1);
        serve("t5_f1c0", 24'h000000, 512, 1'b0, -1);
        serve("t5_f1c1", 24'h000200, 512, 1'b1, -1);
        check("t5_rd_bank", 32'(rd_bank), 32'd1);

        // Reset in the middle of a data phase abandons the burst.
        config_dut(12'd512, 13'd2, 10'd512, 11'd600, 11'd600, 1'b1);
        do_reset();
        req_seen = 0;
        while (!sdram_wr_req && req_seen < 100) begin @(negedge clk); req_seen++; end
        check("t6_req", 32'(sdram_wr_req), 32'd1);
        repeat (10) begin sdram_wr_ack = 1'b1; @(negedge clk); end
        #1;
        check("t6_mid_rden", 32'(fifo0_rden), 32'd1);
        rst          = 1'b1;
        sdram_wr_ack = 1'b0;
        @(negedge clk);
        check("t6_rst_req", 32'(sdram_wr_req), 32'd0);
        check("t6_rst_addr", 32'(sdram_wr_addr), 32'd0);
        check("t6_rst_burst", 32'(sdram_wr_burst), 32'd0);
        sdram_wr_ack = 1'b1;
        #1;
        check("t6_rst_rden", {30'd0, fifo1_rden, fifo0_rden}, 32'd0);
        sdram_wr_ack = 1'b0;
        check("t6_rst_rd_bank", 32'(rd_bank), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        serve("t6_after", 24'h000000, 512, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
